// File: rtl/freq_div_pkg.sv
// Shared state encoding and default parameters for the divided-clock monitor.
package freq_div_pkg;

  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_EXP_PERIOD = 7;
  localparam int unsigned DEF_TOL        = 0;
  localparam int unsigned DEF_LOCK_N     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } fdm_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, plus a delayed copy for rising-edge detection.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s2,
  output logic rise
);

  logic s1;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;

endmodule

// File: rtl/freq_div_monitor.sv
// Measures period and high time of a divided clock, flags ratio/duty errors and tracks lock.
module freq_div_monitor
  import freq_div_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_N     = DEF_LOCK_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_err,
  output logic             duty_err,
  output logic             lock,
  output logic             timeout
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam int unsigned       GCNT_W   = $clog2(LOCK_N + 1);
  localparam logic [GCNT_W-1:0] GCNT_MAX = GCNT_W'(LOCK_N);
  localparam int unsigned       DUTY_LO  = EXP_PERIOD / 2;
  localparam int unsigned       DUTY_HI  = (EXP_PERIOD + 1) / 2;

  fdm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [GCNT_W-1:0] gcnt_inc;
  logic [CNT_W-1:0]  period_d, high_time_d;
  logic              period_err_d, duty_err_d, lock_d, meas_valid_d, timeout_d;
  logic              period_bad, duty_bad;
  logic              s2, rise;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .s2     (s2),
    .rise   (rise)
  );

  // Error checks on the count that is about to be latched as a measurement.
  always_comb begin
    if (32'(pcnt_q) > EXP_PERIOD) begin
      period_bad = (32'(pcnt_q) - EXP_PERIOD) > TOL;
    end else begin
      period_bad = (EXP_PERIOD - 32'(pcnt_q)) > TOL;
    end
    duty_bad = (32'(hcnt_q) < DUTY_LO) || (32'(hcnt_q) > DUTY_HI);
  end

  assign gcnt_inc = (gcnt_q == GCNT_MAX) ? gcnt_q : gcnt_q + GCNT_W'(1);

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    hcnt_d       = hcnt_q;
    gcnt_d       = gcnt_q;
    period_d     = period;
    high_time_d  = high_time;
    period_err_d = period_err;
    duty_err_d   = duty_err;
    lock_d       = lock;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
      gcnt_d  = '0;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pcnt_d  = '0;
          hcnt_d  = '0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          if (rise) begin
            pcnt_d  = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // A rise on the saturating cycle still yields a normal measurement.
          if (rise) begin
            period_d     = pcnt_q;
            high_time_d  = hcnt_q;
            period_err_d = period_bad;
            duty_err_d   = duty_bad;
            meas_valid_d = 1'b1;
            pcnt_d       = CNT_W'(1);
            hcnt_d       = CNT_W'(1);
            if (period_bad || duty_bad) begin
              gcnt_d = '0;
              lock_d = 1'b0;
            end else begin
              gcnt_d = gcnt_inc;
              lock_d = (gcnt_inc == GCNT_MAX);
            end
          end else if (pcnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            gcnt_d    = '0;
            lock_d    = 1'b0;
            pcnt_d    = '0;
            hcnt_d    = '0;
            state_d   = ST_ARM;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
            hcnt_d = hcnt_q + CNT_W'(s2);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      hcnt_q     <= '0;
      gcnt_q     <= '0;
      period     <= '0;
      high_time  <= '0;
      period_err <= 1'b0;
      duty_err   <= 1'b0;
      lock       <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      hcnt_q     <= hcnt_d;
      gcnt_q     <= gcnt_d;
      period     <= period_d;
      high_time  <= high_time_d;
      period_err <= period_err_d;
      duty_err   <= duty_err_d;
      lock       <= lock_d;
      meas_valid <= meas_valid_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_freq_div_monitor.sv
// Randomised bench: two monitor configurations checked against a rise-timestamp reference model.
module tb_freq_div_monitor;

  localparam int MAX_EDGES = 8000;
  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;

  typedef struct packed {
    int mode;
    int t_a;
    int gcnt;
    int period;
    int high;
    bit perr;
    bit derr;
    bit lock;
    bit mv;
    bit to;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n, en, sig_in;

  logic       mv_a, perr_a, derr_a, lock_a, to_a;
  logic [7:0] period_a, high_a;
  logic       mv_b, perr_b, derr_b, lock_b, to_b;
  logic [3:0] period_b, high_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_edge = 0;
  bit   s2_at [0:MAX_EDGES-1];
  bit   smp1 = 1'b0, smp2 = 1'b0, smp3 = 1'b0;
  mdl_t m_a = '0;
  mdl_t m_b = '0;

  always #5 clk = ~clk;

  freq_div_monitor #(.CNT_W(8), .EXP_PERIOD(7), .TOL(0), .LOCK_N(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .meas_valid(mv_a), .period(period_a), .high_time(high_a),
    .period_err(perr_a), .duty_err(derr_a), .lock(lock_a), .timeout(to_a)
  );

  freq_div_monitor #(.CNT_W(4), .EXP_PERIOD(7), .TOL(1), .LOCK_N(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .meas_valid(mv_b), .period(period_b), .high_time(high_b),
    .period_err(perr_b), .duty_err(derr_b), .lock(lock_b), .timeout(to_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, n_edge, got, exp);
    end
  endtask

  // Period = distance between accepted rises; high time = synchronised-high cycles in that window.
  function automatic mdl_t model_step(input mdl_t mi, input int cw, input int ep, input int tol,
                                      input int ln, input bit r, input bit e, input bit rs,
                                      input int n);
    mdl_t m;
    int   hs;
    int   dev;
    m    = mi;
    m.mv = 1'b0;
    m.to = 1'b0;
    if (!r) return '0;
    if (!e) begin
      m.mode = M_IDLE;
      m.gcnt = 0;
      m.lock = 1'b0;
      return m;
    end
    if (m.mode == M_IDLE) begin
      m.mode = M_ARM;
    end else if (m.mode == M_ARM) begin
      if (rs) begin
        m.t_a  = n;
        m.mode = M_RUN;
      end
    end else if (rs) begin
      hs = 0;
      for (int i = m.t_a; i < n; i++) hs += int'(s2_at[i]);
      m.period = n - m.t_a;
      m.high   = hs;
      dev      = m.period - ep;
      if (dev < 0) dev = -dev;
      m.perr = (dev > tol);
      m.derr = (hs < ep / 2) || (hs > (ep + 1) / 2);
      m.gcnt = (m.perr || m.derr) ? 0 : m.gcnt + 1;
      m.lock = (m.gcnt >= ln);
      m.mv   = 1'b1;
      m.t_a  = n;
    end else if (n - m.t_a == (1 << cw) - 1) begin
      m.to   = 1'b1;
      m.gcnt = 0;
      m.lock = 1'b0;
      m.mode = M_ARM;
    end
    return m;
  endfunction

  task automatic compare_all();
    check_val("a.meas_valid", 32'(mv_a),     32'(m_a.mv));
    check_val("a.timeout",    32'(to_a),     32'(m_a.to));
    check_val("a.lock",       32'(lock_a),   32'(m_a.lock));
    check_val("a.period",     32'(period_a), 32'(m_a.period));
    check_val("a.high_time",  32'(high_a),   32'(m_a.high));
    check_val("a.period_err", 32'(perr_a),   32'(m_a.perr));
    check_val("a.duty_err",   32'(derr_a),   32'(m_a.derr));
    check_val("b.meas_valid", 32'(mv_b),     32'(m_b.mv));
    check_val("b.timeout",    32'(to_b),     32'(m_b.to));
    check_val("b.lock",       32'(lock_b),   32'(m_b.lock));
    check_val("b.period",     32'(period_b), 32'(m_b.period));
    check_val("b.high_time",  32'(high_b),   32'(m_b.high));
    check_val("b.period_err", 32'(perr_b),   32'(m_b.perr));
    check_val("b.duty_err",   32'(derr_b),   32'(m_b.derr));
  endtask

  // One clk cycle: drive at negedge, advance the reference at posedge, compare just after.
  task automatic step(input bit r, input bit e, input bit x);
    bit rs;
    @(negedge clk);
    rst_n  = r;
    en     = e;
    sig_in = x;
    @(posedge clk);
    if (n_edge >= MAX_EDGES) begin
      $display("FAIL edge_budget: got %0d expected below %0d", n_edge, MAX_EDGES);
      $fatal(1);
    end
    s2_at[n_edge] = smp2;
    rs  = smp2 & ~smp3;
    m_a = model_step(m_a, 8, 7, 0, 4, r, e, rs, n_edge);
    m_b = model_step(m_b, 4, 7, 1, 2, r, e, rs, n_edge);
    if (!r) begin
      smp1 = 1'b0; smp2 = 1'b0; smp3 = 1'b0;
    end else begin
      smp3 = smp2; smp2 = smp1; smp1 = x;
    end
    n_edge++;
    #1;
    compare_all();
  endtask

  task automatic wave(input int p, input int h0, input int h1, input int nper);
    for (int k = 0; k < nper; k++)
      for (int c = 0; c < p; c++)
        step(1'b1, 1'b1, c < (((k % 2) != 0) ? h1 : h0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int p, h0, h1;
    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat ($urandom_range(1, 6)) step(1'b1, 1'b1, 1'b0);

    // Divide-by-7 dual-edge output: high alternates 4/3.
    wave(7, 4, 3, 10);
    // Period 8, then back to 7; then period 9.
    wave(8, 4, 4, 6);
    wave(7, 3, 4, 8);
    wave(9, 4, 5, 5);
    wave(7, 4, 3, 6);

    // Input stuck high: both configurations saturate.
    repeat (300) step(1'b1, 1'b1, 1'b1);
    wave(7, 4, 3, 6);

    // Enable dropped for one cycle mid-period.
    repeat (3) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    wave(7, 4, 3, 6);

    // Reset pulse mid-measurement.
    repeat (2) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    wave(7, 3, 4, 6);

    // Random periods, duties, enable drops and resets.
    repeat (60) begin
      p  = $urandom_range(3, 12);
      h0 = $urandom_range(1, p - 1);
      h1 = ($urandom_range(0, 1) != 0) ? h0 : $urandom_range(1, p - 1);
      wave(p, h0, h1, $urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    end
    wave(7, 4, 3, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_div_monitor.md
# freq_div_monitor

Single-clock monitor that consumes the output of the divide-by-N clock dividers (e.g. the divide-by-7 stage) and checks it against the expected ratio. The divided signal is synchronised into `clk` and its rising edges are detected. The block measures period and high time in `clk` cycles, flags ratio and duty errors, and declares lock after a run of good periods. It sits directly downstream of the divider and feeds status/debug logic.

## Interface
- `CNT_W`, 8: width of period/high-time counters and outputs.
- `EXP_PERIOD`, 7: expected period of `sig_in` in `clk` cycles.
- `TOL`, 0: allowed absolute period deviation in cycles.
- `LOCK_N`, 4: consecutive good measurements required for lock (≥1).

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `en`, in, 1: enable; low forces IDLE.
- `sig_in`, in, 1: divided signal, asynchronous to `clk` sampling.
- `meas_valid`, out, 1: one-cycle pulse; a new measurement is on the outputs.
- `period`, out, CNT_W: last measured period in cycles.
- `high_time`, out, CNT_W: sampled-high cycles in the last period.
- `period_err`, out, 1: `|period − EXP_PERIOD| > TOL`. Valid with `meas_valid` and held until the next one.
- `duty_err`, out, 1: `high_time` outside [EXP_PERIOD/2, (EXP_PERIOD+1)/2] (integer division). Held like `period_err`.
- `lock`, out, 1: LOCK_N consecutive good measurements seen.
- `timeout`, out, 1: one-cycle pulse when the period counter saturates.

## Operation
- Input path:
  - `sig_in` → `s1` → `s2` (2-flop synchroniser), then `s2` → `prev`.
  - Rise is combinational: `rise = s2 & ~prev`.
- FSM states: IDLE, ARM, RUN.
  - IDLE: counters cleared. Goes to ARM when `en` = 1.
  - ARM: waits for `rise`. On `rise`: `pcnt` = 1, `hcnt` = 1, go to RUN. No measurement is produced.
  - RUN, each cycle without `rise`: `pcnt` += 1; `hcnt` += `s2`.
  - RUN, on `rise`:
    - Latch `period` = `pcnt` and `high_time` = `hcnt`.
    - Compute the errors and pulse `meas_valid`.
    - Reload `pcnt` = 1, `hcnt` = 1.
- Saturation: if `pcnt` reaches 2^CNT_W−1 without a `rise`:
  - pulse `timeout`, clear `lock` and the good-count, go to ARM.
  - `period` and `high_time` are not updated.
- Lock counter (`gcnt`), saturating at LOCK_N:
  - Good measurement (no `period_err`, no `duty_err`): `gcnt` += 1.
  - Any bad measurement: `gcnt` = 0 and `lock` = 0.
  - `lock` = 1 when `gcnt` reaches LOCK_N.
- `en` low in any state: go to IDLE next cycle; clear `lock`, `gcnt`, `pcnt`, `hcnt`. `period`, `high_time` and the error flags keep their last values.
- Simultaneous `rise` and saturation: `rise` wins and a normal measurement is taken.
- `rst_n` low: all state and outputs go to 0, FSM to IDLE. This applies mid-measurement too; no partial result is emitted.

## Timing
- First clk posedge that samples `sig_in` = 1 is cycle k. Then `s2` = 1 at k+1, `rise` at k+1, and `meas_valid`, `period`, flags and `lock` update registered at k+2.
- Latency from a `sig_in` rising edge to its measurement: 2 cycles after capture.
- `period` equals the cycle distance between consecutive detected rises.
- A divide-by-7 dual-edge output sampled at posedge gives `period` = 7 and `high_time` alternating 3/4, which passes both checks.
- `meas_valid` is never high on two consecutive cycles when EXP_PERIOD ≥ 2.
- `timeout` registered, coincident with the ARM transition.

## Structure
- Package `freq_div_pkg`: FSM state enum (IDLE/ARM/RUN), default constants for CNT_W, EXP_PERIOD, LOCK_N.
- Sub-module `sync_edge_det`: 2-flop synchroniser plus `prev` register. Outputs `s2` and `rise`. Uses `clk` and `rst_n`.
- Top holds the FSM, counters, compare logic and lock logic.

## Test plan
- Divide-by-7 dual-edge stimulus, `en` = 1 → `period` = 7 each `meas_valid`; `high_time` ∈ {3,4}; no errors; `lock` rises on the 4th measurement.
- Period 8 (high 4) with defaults → `period` = 8, `period_err` = 1, `lock` stays 0; then switch back to 7 → `lock` after 4 good measurements.
- `sig_in` held high after lock, CNT_W = 4 → `timeout` pulses when `pcnt` reaches 15; `lock` = 0; FSM in ARM; no `meas_valid` on the next `rise`.
- `en` dropped mid-period for 1 cycle → `lock` = 0, last `period` retained; first measurement after re-enable only at the second rise.
- `rst_n` = 0 for 1 cycle mid-measurement → all outputs 0 the next cycle; sequence restarts with ARM.
- TOL = 1, period 8 → `period_err` = 0; period 9 → `period_err` = 1.
